branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 157 +++++++++++++++
 tb/tb_branch_predictor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters.
// Predicts in IF and trains from resolved EX branches.
//
// Ports:
//   clk, rst          clock, sync active-high reset
//   if_pc             fetch PC to predict
//   pred_taken        predicted taken for if_pc
//   pred_target       predicted target (0 when not taken)
//   ex_valid, ex_pc   EX instruction valid and PC
//   ex_is_br          EX instruction is branch/jump
//   ex_taken          resolved direction
//   ex_target         resolved target
//   ex_pred_taken     prediction carried with the instr
//   ex_pred_target    predicted target carried down
//   mispredict        flush IF/ID and redirect fetch
//   redirect_pc       corrected fetch PC
//   stat_branches     resolved branch count
//   stat_mispredicts  mispredict count
//
// Macro BPU_STATS_EN enables the two stat counters;
// without it both stat outputs are tied to zero.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_br,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;

  // Byte-offset bits of a word-aligned target are never stored.
  logic unused_ok;
  assign unused_ok = ^{ex_target[1:0], if_pc[1:0]};

  // Lookup
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign if_hit = vld_q[if_idx]
               && (tag_q[if_idx] == if_tag);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (!rst && if_hit && ctr_q[if_idx][1]) begin
      pred_taken  = 1'b1;
      pred_target = {tgt_q[if_idx], 2'b00};
    end
  end

  // Resolve
  assign upd = ex_valid & ex_is_br & ~rst;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = 32'h0;
    if (upd) begin
      mispredict = (ex_taken != ex_pred_taken)
                 | (ex_taken & ex_pred_taken
                    & (ex_target != ex_pred_target));
    end
    if (mispredict) begin
      redirect_pc = ex_taken ? ex_target
                             : ex_pc + 32'd4;
    end
  end

  // Training
  assign ex_idx  = ex_pc[IDX_W+1:2];
  assign ex_tag  = ex_pc[31:IDX_W+2];
  assign ex_hit  = vld_q[ex_idx]
                && (tag_q[ex_idx] == ex_tag);
  assign ctr_cur = ctr_q[ex_idx];
  assign ctr_inc = (ctr_cur == 2'b11) ? 2'b11
                                      : ctr_cur + 2'd1;
  assign ctr_dec = (ctr_cur == 2'b00) ? 2'b00
                                      : ctr_cur - 2'd1;

  // Valid bits and counters carry reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_taken ? ctr_inc : ctr_dec;
      end else if (ex_taken) begin
        vld_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx] <= 2'b10;
      end
    end
  end

  // Tag/target need no reset: valid gates their use,
  // and upd is already low while rst is high.
  always_ff @(posedge clk) begin
    if (upd && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target[31:2];
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] misp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= 32'h0;
      misp_cnt <= 32'h0;
    end else begin
      if (upd)        br_cnt   <= br_cnt + 32'd1;
      if (mispredict) misp_cnt <= misp_cnt + 32'd1;
    end
  end

  assign stat_branches    = br_cnt;
  assign stat_mispredicts = misp_cnt;
`else
  assign stat_branches    = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed bench for branch_predictor.
// Define BPU_STATS_EN to also exercise the stat counters.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_br;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PA = 32'h1C00_0010;
  localparam logic [31:0] PB = 32'h1C00_0050;
  localparam logic [31:0] PC = 32'h1C00_0080;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_is_br         (ex_is_br),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic look(input string tag,
                      input logic [31:0] pc,
                      input logic        et,
                      input logic [31:0] etg);
    if_pc = pc;
    #1;
    check({tag, ".pt"}, {31'h0, pred_taken},
          {31'h0, et});
    check({tag, ".ptg"}, pred_target, etg);
  endtask

  // Drive one resolve after a negedge, check, clock it.
  task automatic resolve(input string tag,
                         input logic [31:0] pc,
                         input logic        tk,
                         input logic [31:0] tg,
                         input logic        ptk,
                         input logic [31:0] ptg,
                         input logic        em,
                         input logic [31:0] er);
    ex_valid       = 1'b1;
    ex_is_br       = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    #1;
    check({tag, ".mp"}, {31'h0, mispredict},
          {31'h0, em});
    check({tag, ".rd"}, redirect_pc, er);
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    if_pc          = PA;
    ex_valid       = 1'b1;
    ex_is_br       = 1'b1;
    ex_pc          = PA;
    ex_taken       = 1'b1;
    ex_target      = 32'h1C00_0100;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;

    // Reset with a training request present.
    @(negedge clk);
    #1;
    check("rst.mp", {31'h0, mispredict}, 32'h0);
    check("rst.rd", redirect_pc, 32'h0);
    check("rst.pt", {31'h0, pred_taken}, 32'h0);
    check("rst.sb", stat_branches, 32'h0);
    check("rst.sm", stat_mispredicts, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    ex_valid = 1'b0;
    look("por", 32'h1C00_0000, 1'b0, 32'h0);
    look("rdisc", PA, 1'b0, 32'h0);

    // Idle cycles: invalid instr must not train.
    for (int i = 0; i < 10; i++) begin
      #1;
      check("idle.mp", {31'h0, mispredict}, 32'h0);
      @(negedge clk);
    end
    look("idle", PA, 1'b0, 32'h0);

    // Valid non-branch must not train or flush.
    ex_valid = 1'b1;
    ex_is_br = 1'b0;
    #1;
    check("nbr.mp", {31'h0, mispredict}, 32'h0);
    @(negedge clk);
    ex_valid = 1'b0;
    look("nbr", PA, 1'b0, 32'h0);

    // Allocate; same-cycle lookup sees old contents.
    if_pc = PA;
    resolve("a", PA, 1, 32'h1C00_0100, 0, 0,
            1, 32'h1C00_0100);
    look("a", PA, 1'b1, 32'h1C00_0100);
    // 10 -> 01
    resolve("b", PA, 0, 0, 1, 32'h1C00_0100,
            1, 32'h1C00_0014);
    look("b", PA, 1'b0, 32'h0);
    // 01 -> 00 -> 00
    resolve("c", PA, 0, 0, 0, 0, 0, 32'h0);
    resolve("d", PA, 0, 0, 0, 0, 0, 32'h0);
    // 00 -> 01: still not taken
    resolve("e", PA, 1, 32'h1C00_0100, 0, 0,
            1, 32'h1C00_0100);
    look("e", PA, 1'b0, 32'h0);
    // 01 -> 10
    resolve("f", PA, 1, 32'h1C00_0100, 0, 0,
            1, 32'h1C00_0100);
    look("f", PA, 1'b1, 32'h1C00_0100);
    // 10 -> 11, correct prediction
    resolve("g", PA, 1, 32'h1C00_0100,
            1, 32'h1C00_0100, 0, 32'h0);
    // Wrong target: 11 stays 11, target replaced
    resolve("h", PA, 1, 32'h1C00_0200,
            1, 32'h1C00_0100, 1, 32'h1C00_0200);
    look("h", PA, 1'b1, 32'h1C00_0200);
    // 11 -> 10, target kept
    resolve("i", PA, 0, 0, 1, 32'h1C00_0200,
            1, 32'h1C00_0014);
    look("i", PA, 1'b1, 32'h1C00_0200);
    // 10 -> 01
    resolve("j", PA, 0, 0, 1, 32'h1C00_0200,
            1, 32'h1C00_0014);
    look("j", PA, 1'b0, 32'h0);

    // Alias with differing tag evicts PA.
    resolve("k", PB, 1, 32'h1C00_0300, 0, 0,
            1, 32'h1C00_0300);
    look("kb", PB, 1'b1, 32'h1C00_0300);
    look("ka", PA, 1'b0, 32'h0);

    // Fall-through redirect wraps at 32 bits.
    resolve("w", 32'hFFFF_FFFC, 0, 0,
            1, 32'h1C00_0000, 1, 32'h0);

    // Reset during an allocate: nothing written.
    rst            = 1'b1;
    if_pc          = PB;
    ex_valid       = 1'b1;
    ex_is_br       = 1'b1;
    ex_pc          = PA;
    ex_taken       = 1'b1;
    ex_target      = 32'h1C00_0400;
    ex_pred_taken  = 1'b0;
    #1;
    check("r.mp", {31'h0, mispredict}, 32'h0);
    check("r.rd", redirect_pc, 32'h0);
    check("r.pt", {31'h0, pred_taken}, 32'h0);
    check("r.ptg", pred_target, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    ex_valid = 1'b0;
    look("ra", PA, 1'b0, 32'h0);
    look("rb", PB, 1'b0, 32'h0);

    // Five branches, two mispredicts.
    resolve("s1", PC, 0, 0, 0, 0, 0, 32'h0);
    resolve("s2", PC, 0, 0, 0, 0, 0, 32'h0);
    resolve("s3", PC, 1, 32'h1C00_0500, 0, 0,
            1, 32'h1C00_0500);
    resolve("s4", PC, 1, 32'h1C00_0500,
            1, 32'h1C00_0500, 0, 32'h0);
    resolve("s5", PC, 0, 0, 1, 32'h1C00_0500,
            1, 32'h1C00_0084);
`ifdef BPU_STATS_EN
    check("st.br", stat_branches, 32'd5);
    check("st.mp", stat_mispredicts, 32'd2);
    force dut.br_cnt   = 32'hFFFF_FFFF;
    force dut.misp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt;
    release dut.misp_cnt;
    resolve("s6", PC, 1, 32'h1C00_0600,
            1, 32'h1C00_0500, 1, 32'h1C00_0600);
    check("wr.br", stat_branches, 32'h0);
    check("wr.mp", stat_mispredicts, 32'h0);
`else
    check("st.br", stat_branches, 32'h0);
    check("st.mp", stat_mispredicts, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
